// File: rtl/mvu_pe_xnor_acc_ctrl.sv
// Binary MVU processing element: popcount(act XNOR wgt) accumulated over SF beats, one result per fold.
// Result valid the cycle after the SF-th beat; input stalls (in_rdy=0) while a result waits on out_rdy.
module mvu_pe_xnor_acc_ctrl #(
  parameter int SIMD  = 8,
  parameter int SF    = 4,
  parameter int TDstI = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_v,
  output logic             in_rdy,
  input  logic [SIMD-1:0]  in_act,
  input  logic [SIMD-1:0]  in_wgt,
  output logic             out_v,
  input  logic             out_rdy,
  output logic [TDstI-1:0] out,
  output logic             busy
);

  localparam int CW = (SF > 1) ? $clog2(SF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SF - 1);

  generate
    if (SF < 1 || SF > 1024) begin : g_bad_sf
      $error("mvu_pe_xnor_acc_ctrl: SF must be in 1..1024");
    end
    if (TDstI < $clog2(SIMD * SF + 1)) begin : g_bad_width
      $error("mvu_pe_xnor_acc_ctrl: TDstI too narrow for SIMD*SF");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TDstI-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TDstI-1:0]  out_q, out_d;

  logic [SIMD-1:0]   match;
  logic [TDstI-1:0]  contrib;
  logic [TDstI-1:0]  sum;

  always_comb begin
    match   = ~(in_act ^ in_wgt);
    contrib = '0;
    for (int i = 0; i < SIMD; i++) begin
      contrib = contrib + TDstI'(match[i]);
    end
    sum = acc_q + contrib;
  end

  // Handshake flags depend only on the state register, never on in_v/out_rdy.
  assign in_rdy = (state_q != S_OUT);
  assign out_v  = (state_q == S_OUT);
  assign busy   = (state_q != S_IDLE);
  assign out    = out_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (in_v) begin
          if (SF == 1) begin
            out_d   = contrib;
            state_d = S_OUT;
          end else begin
            acc_d   = contrib;
            cnt_d   = CW'(1);
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (in_v) begin
          acc_d = sum;
          if (cnt_q == CNT_LAST) begin
            out_d   = sum;
            cnt_d   = '0;
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_OUT: begin
        if (out_rdy) begin
          acc_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

endmodule
